// File: rtl/quad_pkg.sv
// Shared phase-state encodings, direction codes and the transition decoder
// for the quadrature decoder.
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    DEC_NONE = 2'd0,
    DEC_UP   = 2'd1,
    DEC_DN   = 2'd2,
    DEC_ILL  = 2'd3
  } dec_t;

  // Classify an accepted {A,B} transition; both bits flipping is illegal.
  function automatic dec_t quad_decode(input logic [1:0] prev, input logic [1:0] nxt);
    dec_t d;
    d = DEC_NONE;
    if ((prev ^ nxt) == 2'b11) begin
      d = DEC_ILL;
    end else begin
      case ({prev, nxt})
        {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: d = DEC_UP;
        {PH_01, PH_00}, {PH_11, PH_01}, {PH_10, PH_11}, {PH_00, PH_10}: d = DEC_DN;
        default: d = DEC_NONE;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Two-flop synchroniser for both phases followed by a stability filter that
// accepts a phase state once it has been seen for FILTER consecutive clocks.
module quad_sync_filter
  import quad_pkg::*;
#(
  parameter int unsigned FILTER = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] phase,
  output logic [1:0] state,
  output logic [1:0] prev,
  output logic       accept
);

  localparam int unsigned CNT_W = 4;

  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       fill;
  logic [1:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic             differ_c;
  logic             bump_c;
  logic             done_c;
  logic [CNT_W-1:0] cnt_nxt_c;

  // The synchroniser's reset zeros are not pin samples; fill masks them so a
  // part powered up with A=B=1 is not mistaken for a 00 -> 11 jump.
  always_comb begin
    differ_c  = (sync2 != cand);
    bump_c    = fill[1] && (differ_c || (cnt < CNT_W'(FILTER)));
    cnt_nxt_c = differ_c ? CNT_W'(1) : cnt + CNT_W'(1);
    done_c    = bump_c && (cnt_nxt_c == CNT_W'(FILTER));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= PH_00;
      sync2  <= PH_00;
      fill   <= 2'b00;
      cand   <= PH_00;
      cnt    <= '0;
      state  <= PH_00;
      prev   <= PH_00;
      accept <= 1'b0;
    end else begin
      sync1  <= phase;
      sync2  <= sync1;
      fill   <= {fill[0], 1'b1};
      accept <= done_c;
      if (bump_c) begin
        cand <= sync2;
        cnt  <= cnt_nxt_c;
      end
      if (done_c) begin
        prev  <= state;
        state <= sync2;
      end
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: filtered phase tracking, up/down position counter with
// load, direction bit, step pulse and sticky illegal-transition flag.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned FILTER = 2
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             A,
  input  logic             B,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             ErrClr,
  output logic [WIDTH-1:0] Q,
  output logic             M,
  output logic             Step,
  output logic             Err
);

  logic [1:0] acc_state;
  logic [1:0] acc_prev;
  logic       accept;
  logic       init;
  dec_t       dec_c;
  logic       move_c;

  quad_sync_filter #(.FILTER(FILTER)) u_filter (
    .clk    (Clk),
    .rst_n  (Clr),
    .phase  ({A, B}),
    .state  (acc_state),
    .prev   (acc_prev),
    .accept (accept)
  );

  // The first acceptance after reset only establishes the reference state.
  always_comb begin
    dec_c  = (accept && !init) ? quad_decode(acc_prev, acc_state) : DEC_NONE;
    move_c = En && ((dec_c == DEC_UP) || (dec_c == DEC_DN));
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      Q    <= '0;
      M    <= DIR_UP;
      Step <= 1'b0;
      Err  <= 1'b0;
      init <= 1'b1;
    end else begin
      Step <= 1'b0;
      if (accept) begin
        init <= 1'b0;
      end
      if (dec_c == DEC_ILL) begin
        Err <= 1'b1;
      end else if (ErrClr) begin
        Err <= 1'b0;
      end
      if (move_c) begin
        M <= (dec_c == DEC_DN) ? DIR_DN : DIR_UP;
      end
      if (Load) begin
        Q <= D;
      end else if (move_c) begin
        Q    <= (dec_c == DEC_UP) ? Q + WIDTH'(1) : Q - WIDTH'(1);
        Step <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder: directed tables and sequences
// plus randomized phase activity compared every cycle to a sample-level model.
module tb_quadrature_decoder;

  localparam int unsigned WIDTH  = 3;
  localparam int unsigned FILTER = 2;
  localparam int          MODV   = 1 << WIDTH;

  logic             Clk = 1'b0;
  logic             Clr;
  logic             A;
  logic             B;
  logic             En;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic             ErrClr;
  logic [WIDTH-1:0] Q;
  logic             M;
  logic             Step;
  logic             Err;

  int errors   = 0;
  int checks   = 0;
  int step_cnt = 0;

  always #5 Clk = ~Clk;

  quadrature_decoder #(.WIDTH(WIDTH), .FILTER(FILTER)) dut (
    .Clk(Clk), .Clr(Clr), .A(A), .B(B), .En(En), .Load(Load), .D(D),
    .ErrClr(ErrClr), .Q(Q), .M(M), .Step(Step), .Err(Err)
  );

  // Position of each {A,B} value along the up sequence 00,01,11,10.
  int         pos_tab[4] = '{0, 1, 3, 2};
  logic [1:0] ph_tab[4]  = '{2'b00, 2'b01, 2'b11, 2'b10};

  // Reference model state: raw pin samples, run length of the delayed sample
  // stream, accepted state and the pending transition code.
  logic [1:0] samp_q[$];
  int         run;
  bit         have_seen;
  logic [1:0] last_seen;
  logic [1:0] m_acc;
  bit         m_init;
  int         m_pend;  // 0 none, 1 up, 2 illegal, 3 down
  int         m_q;
  bit         m_m, m_step, m_err;

  function automatic int classify(input logic [1:0] p, input logic [1:0] n);
    return (pos_tab[n] - pos_tab[p] + 4) % 4;
  endfunction

  task automatic model_reset();
    samp_q.delete();
    run = 0; have_seen = 0; last_seen = 2'b00; m_acc = 2'b00; m_init = 1;
    m_pend = 0; m_q = 0; m_m = 0; m_step = 0; m_err = 0;
  endtask

  task automatic model_edge();
    logic [1:0] seen;
    bit mv;
    if (!Clr) begin
      model_reset();
      return;
    end
    m_step = 0;
    mv = En && (m_pend == 1 || m_pend == 3);
    if (m_pend == 2) m_err = 1;
    else if (ErrClr) m_err = 0;
    if (mv) m_m = (m_pend == 3);
    if (Load) begin
      m_q = int'(D);
    end else if (mv) begin
      m_q = (m_q + ((m_pend == 1) ? 1 : MODV - 1)) % MODV;
      m_step = 1;
    end
    m_pend = 0;
    // A pin value reaches the filter two clocks after it is sampled.
    samp_q.push_back({A, B});
    if (samp_q.size() > 2) begin
      seen = samp_q.pop_front();
      if (have_seen && seen == last_seen) run++;
      else run = 1;
      have_seen = 1;
      last_seen = seen;
      if (run == int'(FILTER)) begin
        if (m_init) m_init = 0;
        else m_pend = classify(m_acc, seen);
        m_acc = seen;
      end
    end
  endtask

  task automatic check_model();
    checks++;
    if (Q !== WIDTH'(m_q) || M !== m_m || Step !== m_step || Err !== m_err) begin
      errors++;
      $display("FAIL model t=%0t: got Q=%0d M=%0b Step=%0b Err=%0b, need Q=%0d M=%0b Step=%0b Err=%0b",
               $time, Q, M, Step, Err, m_q, m_m, m_step, m_err);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, need %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_model();
    if (Step === 1'b1) step_cnt++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_ab(input logic [1:0] ab);
    {A, B} = ab;
  endtask

  typedef struct {
    logic [1:0] ab;
    int         q;
    bit         m;
  } vec_t;

  vec_t up_vec[32];
  vec_t dn_vec[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int qprev;
    logic [1:0] cur;
    int r, hold;

    for (int i = 0; i < 32; i++) begin
      up_vec[i].ab = ph_tab[(i + 1) % 4];
      up_vec[i].q  = (i + 1) % MODV;
      up_vec[i].m  = 0;
    end
    for (int i = 0; i < 4; i++) begin
      dn_vec[i].ab = ph_tab[(4 - (i + 1)) % 4];
      dn_vec[i].q  = (2 - (i + 1) + MODV) % MODV;
      dn_vec[i].m  = 1;
    end

    Clr = 0; A = 0; B = 0; En = 1; Load = 0; D = '0; ErrClr = 0;
    model_reset();
    ticks(2);
    chk("reset_q", int'(Q), 0);
    chk("reset_m", int'(M), 0);
    chk("reset_step", int'(Step), 0);
    chk("reset_err", int'(Err), 0);
    Clr = 1;
    ticks(8);

    // 1: eight full up cycles wrap the 3-bit count back to 0
    s0 = step_cnt;
    for (int i = 0; i < 32; i++) begin
      set_ab(up_vec[i].ab);
      ticks(8);
      chk("t1_q", int'(Q), up_vec[i].q);
      chk("t1_m", int'(M), int'(up_vec[i].m));
    end
    chk("t1_steps", step_cnt - s0, 32);
    chk("t1_final_q", int'(Q), 0);

    // 2: reverse sequence from 2, with exact update latency
    Load = 1; D = 3'd2;
    tick();
    Load = 0;
    chk("t2_load_q", int'(Q), 2);
    s0 = step_cnt;
    qprev = 2;
    for (int i = 0; i < 4; i++) begin
      set_ab(dn_vec[i].ab);
      ticks(4);
      chk("t2_early_step", int'(Step), 0);
      chk("t2_early_q", int'(Q), qprev);
      tick();
      chk("t2_step", int'(Step), 1);
      chk("t2_q", int'(Q), dn_vec[i].q);
      chk("t2_m", int'(M), int'(dn_vec[i].m));
      qprev = dn_vec[i].q;
      ticks(4);
    end
    chk("t2_steps", step_cnt - s0, 4);
    chk("t2_final_q", int'(Q), 6);

    // 3: single-clock glitches are discarded
    s0 = step_cnt;
    A = 1; tick(); A = 0; ticks(6);
    A = 1; tick(); A = 0; ticks(8);
    chk("t3_steps", step_cnt - s0, 0);
    chk("t3_q", int'(Q), 6);
    chk("t3_err", int'(Err), 0);

    // 4: illegal jump, clear, then clear colliding with a new error
    set_ab(2'b11);
    ticks(10);
    chk("t4_err_set", int'(Err), 1);
    chk("t4_q_hold", int'(Q), 6);
    ErrClr = 1; tick(); ErrClr = 0;
    chk("t4_err_clr", int'(Err), 0);
    set_ab(2'b01);
    ticks(8);
    chk("t4_dn_q", int'(Q), 5);
    chk("t4_dn_m", int'(M), 1);
    set_ab(2'b10);
    ticks(4);
    ErrClr = 1; tick(); ErrClr = 0;
    chk("t4_err_wins", int'(Err), 1);
    chk("t4_q_hold2", int'(Q), 5);
    ticks(4);
    ErrClr = 1; tick(); ErrClr = 0;

    // 5: load beats a step; disabled counting; re-enable
    set_ab(2'b00);
    ticks(4);
    Load = 1; D = 3'd5; tick(); Load = 0;
    chk("t5_load_q", int'(Q), 5);
    chk("t5_load_step", int'(Step), 0);
    chk("t5_load_m", int'(M), 0);
    ticks(4);
    En = 0;
    set_ab(2'b01); ticks(8);
    set_ab(2'b11); ticks(8);
    set_ab(2'b10); ticks(8);
    chk("t5_en0_q", int'(Q), 5);
    En = 1;
    set_ab(2'b00); ticks(8);
    chk("t5_reen_q", int'(Q), 6);
    chk("t5_reen_err", int'(Err), 0);

    // randomized activity: legal steps, illegal jumps, short pulses, controls
    for (int it = 0; it < 300; it++) begin
      cur = {A, B};
      r = $urandom_range(0, 9);
      if (r < 4)      set_ab(ph_tab[(pos_tab[cur] + 1) % 4]);
      else if (r < 8) set_ab(ph_tab[(pos_tab[cur] + 3) % 4]);
      else            set_ab(ph_tab[(pos_tab[cur] + 2) % 4]);
      hold   = $urandom_range(1, 9);
      En     = ($urandom_range(0, 4) != 0);
      Load   = ($urandom_range(0, 9) == 0);
      D      = WIDTH'($urandom);
      ErrClr = ($urandom_range(0, 5) == 0);
      tick();
      Load = 0; ErrClr = 0;
      ticks(hold - 1);
    end
    En = 1;
    ticks(10);

    // 6: reset released with both phases high, then reset mid-filter
    Clr = 0;
    set_ab(2'b11);
    ticks(2);
    Clr = 1;
    ticks(8);
    chk("t6_err", int'(Err), 0);
    chk("t6_q", int'(Q), 0);
    set_ab(2'b10);
    ticks(8);
    chk("t6_up_q", int'(Q), 1);
    s0 = step_cnt;
    set_ab(2'b00);
    ticks(3);
    #2;
    Clr = 0;
    #1;
    chk("t6_async_q", int'(Q), 0);
    chk("t6_async_step", int'(Step), 0);
    model_reset();
    ticks(2);
    Clr = 1;
    ticks(12);
    chk("t6_no_step", step_cnt - s0, 0);
    chk("t6_final_q", int'(Q), 0);
    chk("t6_final_err", int'(Err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
